axis_gpio_bridge: RTL and testbench

AXIS_GPIO_BRIDGE -- requirements
Module: axis_gpio_bridge

---
 rtl/axis_gpio_pkg.sv | 50 +++++
 rtl/gpio_debounce.sv | 57 +++++
 rtl/axis_gpio_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_gpio_bridge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gpio_pkg.sv
// Shared types and ASCII helpers for the AXIS GPIO bridge.
// TX FSM state, CR/LF bytes, hex digit encode/decode.
package axis_gpio_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_PREFIX,
    TX_HEX,
    TX_CRLF
  } tx_state_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } hex_dig_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] nib_to_ascii(
    input logic [3:0] n
  );
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic hex_dig_t ascii_to_nib(
    input logic [7:0] c
  );
    hex_dig_t r;
    r = '0;
    unique case (1'b1)
      (c >= 8'h30 && c <= 8'h39): begin
        r.ok  = 1'b1;
        r.nib = 4'(c - 8'h30);
      end
      (c >= 8'h41 && c <= 8'h46): begin
        r.ok  = 1'b1;
        r.nib = 4'(c - 8'h37);
      end
      (c >= 8'h61 && c <= 8'h66): begin
        r.ok  = 1'b1;
        r.nib = 4'(c - 8'h57);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Switch debouncer: 2-FF synchroniser plus a
// whole-vector stability counter.
module gpio_debounce
  import axis_gpio_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    s1_q <= din;
    s2_q <= s1_q;
  end

  always_comb begin
    cand_d = s2_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (s2_q != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CMAX) db_d = cand_d;
  end

  // Reset adopts the synchronised input so a reset
  // does not fabricate a spurious zero value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q <= s2_q;
      db_q   <= s2_q;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/axis_gpio_bridge.sv
// Bridges debounced switches to an ASCII hex AXIS
// stream, and ASCII hex AXIS frames to the LEDs.
module axis_gpio_bridge
  import axis_gpio_pkg::*;
#(
  parameter int         GPIO_WIDTH      = 16,
  parameter int         DEBOUNCE_CYCLES = 1000,
  parameter int         PREFIX_CHARS    = 2,
  parameter logic [511:0] PREFIX_STRING = 512'("0x"),
  parameter int         INCLUDE_CRLF    = 1,
  parameter int         BYTE_START      = 31
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic [GPIO_WIDTH-1:0] SW,
  output logic [GPIO_WIDTH-1:0] LED,
  input  logic [7:0]            s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,
  output logic [7:0]            m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,
  output logic [11:0]           m00_axis_tuser,
  output logic                  rx_err,
  output logic                  tx_busy
);

  localparam int NIB = GPIO_WIDTH / 4;
  localparam logic [6:0] PRE_LAST = 7'(PREFIX_CHARS - 1);
  localparam logic [6:0] NIB_LAST = 7'(NIB - 1);
  localparam tx_state_e FIRST_ST =
    (PREFIX_CHARS > 0) ? TX_PREFIX : TX_HEX;

  logic [GPIO_WIDTH-1:0] db;

  gpio_debounce #(
    .WIDTH (GPIO_WIDTH),
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (axis_aclk),
    .rst_n(axis_aresetn),
    .din  (SW),
    .dout (db)
  );

  tx_state_e             state_q, state_d;
  logic [6:0]            idx_q, idx_d;
  logic [11:0]           tuser_q, tuser_d;
  logic [GPIO_WIDTH-1:0] val_q, val_d;
  logic [GPIO_WIDTH-1:0] rep_q, rep_d;
  logic                  repv_q, repv_d;
  logic                  tx_beat;
  logic [7:0]            tx_data;
  logic                  tx_last;

  assign tx_beat = (state_q != TX_IDLE) && m00_axis_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tuser_d = tuser_q;
    val_d   = val_q;
    rep_d   = rep_q;
    repv_d  = repv_q;
    unique case (state_q)
      TX_IDLE: begin
        if (!repv_q || db != rep_q) begin
          val_d   = db;
          rep_d   = db;
          repv_d  = 1'b1;
          state_d = FIRST_ST;
          idx_d   = '0;
        end
      end
      TX_PREFIX: begin
        if (tx_beat) begin
          tuser_d = tuser_q + 12'd1;
          if (idx_q == PRE_LAST) begin
            state_d = TX_HEX;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      TX_HEX: begin
        if (tx_beat) begin
          tuser_d = tuser_q + 12'd1;
          if (idx_q == NIB_LAST) begin
            state_d = (INCLUDE_CRLF != 0) ?
                      TX_CRLF : TX_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      TX_CRLF: begin
        if (tx_beat) begin
          tuser_d = tuser_q + 12'd1;
          if (idx_q[0]) begin
            state_d = TX_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = 7'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (state_d == TX_IDLE) tuser_d = '0;
  end

  // Output bytes are decoded from held state, so they
  // cannot move while the sink stalls.
  always_comb begin
    tx_data = '0;
    tx_last = 1'b0;
    unique case (state_q)
      TX_PREFIX: begin
        tx_data = PREFIX_STRING[
          8*(PREFIX_CHARS-1-int'(idx_q)) +: 8];
      end
      TX_HEX: begin
        tx_data = nib_to_ascii(
          val_q[4*(NIB-1-int'(idx_q)) +: 4]);
        tx_last = (idx_q == NIB_LAST) &&
                  (INCLUDE_CRLF == 0);
      end
      TX_CRLF: begin
        tx_data = idx_q[0] ? ASCII_LF : ASCII_CR;
        tx_last = idx_q[0];
      end
      default: ;
    endcase
  end

  logic [11:0]           rx_cnt_q, rx_cnt_d;
  logic [GPIO_WIDTH-1:0] shadow_q, shadow_d;
  logic                  bad_q, bad_d;
  logic                  got_q, got_d;
  logic [GPIO_WIDTH-1:0] led_q, led_d;
  logic                  err_q, err_d;
  logic                  rx_beat;
  logic                  is_dig;
  int                    rel;
  hex_dig_t              dig;

  assign rx_beat = s00_axis_tvalid && axis_aresetn;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    shadow_d = shadow_q;
    bad_d    = bad_q;
    got_d    = got_q;
    led_d    = led_q;
    err_d    = 1'b0;
    rel      = int'(rx_cnt_q) - BYTE_START;
    is_dig   = (rel >= 0) && (rel < NIB);
    dig      = ascii_to_nib(s00_axis_tdata);
    if (rx_beat) begin
      if (is_dig) begin
        if (dig.ok) begin
          shadow_d[4*(NIB-1-rel) +: 4] = dig.nib;
        end else begin
          bad_d = 1'b1;
        end
        if (rel == NIB - 1) got_d = 1'b1;
      end
      if (s00_axis_tlast) begin
        if (got_d && !bad_d) begin
          led_d = shadow_d;
        end else begin
          err_d = 1'b1;
        end
        rx_cnt_d = '0;
        got_d    = 1'b0;
        bad_d    = 1'b0;
      end else if (rx_cnt_q != 12'hFFF) begin
        rx_cnt_d = rx_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q  <= TX_IDLE;
      idx_q    <= '0;
      tuser_q  <= '0;
      val_q    <= '0;
      rep_q    <= '0;
      repv_q   <= 1'b0;
      rx_cnt_q <= '0;
      shadow_q <= '0;
      bad_q    <= 1'b0;
      got_q    <= 1'b0;
      led_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tuser_q  <= tuser_d;
      val_q    <= val_d;
      rep_q    <= rep_d;
      repv_q   <= repv_d;
      rx_cnt_q <= rx_cnt_d;
      shadow_q <= shadow_d;
      bad_q    <= bad_d;
      got_q    <= got_d;
      led_q    <= led_d;
      err_q    <= err_d;
    end
  end

  assign LED             = led_q;
  assign rx_err          = err_q;
  assign tx_busy         = (state_q != TX_IDLE);
  assign s00_axis_tready = axis_aresetn;
  assign m00_axis_tvalid = (state_q != TX_IDLE);
  assign m00_axis_tdata  = tx_data;
  assign m00_axis_tlast  = tx_last;
  assign m00_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_gpio_bridge.sv
// Scoreboard bench for axis_gpio_bridge: queued
// expected TX bytes and LED/rx_err events.
module tb_axis_gpio_bridge;

  logic        clk;
  logic        rstn;
  logic [15:0] SW;
  logic [15:0] LED;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [11:0] m_tuser;
  logic        rx_err;
  logic        tx_busy;

  axis_gpio_bridge #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .axis_aclk      (clk),
    .axis_aresetn   (rstn),
    .SW             (SW),
    .LED            (LED),
    .s00_axis_tdata (s_tdata),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast (s_tlast),
    .s00_axis_tready(s_tready),
    .m00_axis_tdata (m_tdata),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast (m_tlast),
    .m00_axis_tready(m_tready),
    .m00_axis_tuser (m_tuser),
    .rx_err         (rx_err),
    .tx_busy        (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [20:0] tx_q[$];
  logic [16:0] rx_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic void push_msg(input logic [15:0] v);
    string      hx;
    logic [7:0] b[8];
    hx   = "0123456789ABCDEF";
    b[0] = 8'h30;
    b[1] = 8'h78;
    for (int i = 0; i < 4; i++)
      b[2+i] = hx[int'(v[15-4*i -: 4])];
    b[6] = 8'h0D;
    b[7] = 8'h0A;
    for (int k = 0; k < 8; k++)
      tx_q.push_back({k == 7, 12'(k), b[k]});
  endfunction

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || tx_busy) && n < lim) begin
      tick();
      n++;
    end
    check("wait_idle", n < lim, 1);
    repeat (3) tick();
  endtask

  task automatic send_rx(input string dig, input int len);
    for (int k = 0; k < len; k++) begin
      s_tdata  = (k >= 31 && k - 31 < dig.len()) ?
                 dig[k-31] : 8'h2E;
      s_tvalid = 1'b1;
      s_tlast  = (k == len - 1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // TX monitor: pops on every accepted byte, checks
  // that a stalled beat is held unchanged.
  logic        stall;
  logic [20:0] held;
  logic [20:0] got_b;
  logic [20:0] exp_b;

  initial begin
    stall = 1'b0;
    forever begin
      @(negedge clk);
      got_b = {m_tlast, m_tuser, m_tdata};
      if (!rstn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!m_tvalid || got_b != held) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b %h want v=1 %h",
                     m_tvalid, got_b, held);
          end
        end
        if (m_tvalid && m_tready) begin
          stall = 1'b0;
          checks++;
          if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %h want none",
                     got_b);
          end else begin
            exp_b = tx_q.pop_front();
            if (got_b != exp_b) begin
              errors++;
              $display("FAIL tx_byte: got %h want %h",
                       got_b, exp_b);
            end
          end
        end else if (m_tvalid) begin
          stall = 1'b1;
          held  = got_b;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  // LED/rx_err monitor: any LED change or error pulse
  // must match the next queued event.
  logic [15:0] led_prev;
  logic [16:0] exp_r;

  initial begin
    led_prev = '0;
    forever begin
      @(negedge clk);
      if (rx_err || LED != led_prev) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %h want none",
                   {rx_err, LED});
        end else begin
          exp_r = rx_q.pop_front();
          if ({rx_err, LED} != exp_r) begin
            errors++;
            $display("FAIL rx_event: got %h want %h",
                     {rx_err, LED}, exp_r);
          end
        end
      end
      led_prev = LED;
    end
  end

  int   n;
  logic busy_seen;

  initial begin
    rstn     = 1'b0;
    SW       = 16'h0000;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (5) tick();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_led", LED, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_busy", tx_busy, 0);

    push_msg(16'h0000);
    rstn = 1'b1;
    tick();
    check("s_tready_up", s_tready, 1);
    wait_idle(100);

    SW = 16'hA5C3;
    push_msg(16'hA5C3);
    wait_idle(100);

    SW = 16'h0001;
    tick();
    tick();
    SW = 16'hA5C3;
    busy_seen = 1'b0;
    repeat (20) begin
      tick();
      if (tx_busy) busy_seen = 1'b1;
    end
    check("glitch_quiet", busy_seen, 0);

    SW = 16'h1234;
    push_msg(16'h1234);
    n = 0;
    while ((tx_q.size() != 0 || tx_busy) && n < 300) begin
      tick();
      m_tready = (n % 3 == 2);
      n++;
    end
    check("stall_done", n < 300, 1);
    m_tready = 1'b1;
    repeat (3) tick();

    SW = 16'h00FF;
    push_msg(16'h00FF);
    push_msg(16'hBEEF);
    n = 0;
    while (!tx_busy && n < 50) begin
      tick();
      n++;
    end
    check("busy_rise", n < 50, 1);
    SW = 16'hBEEF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_tvalid && m_tready && m_tlast) && n < 50);
    check("first_end", n < 50, 1);
    @(negedge clk);
    @(negedge clk);
    check("regap_tvalid", m_tvalid, 1);
    wait_idle(100);

    rx_q.push_back({1'b0, 16'hBEEF});
    send_rx("beEF", 35);
    repeat (3) tick();
    check("led_beef", LED, 16'hBEEF);
    rx_q.push_back({1'b1, 16'hBEEF});
    send_rx("beGF", 35);
    repeat (3) tick();
    rx_q.push_back({1'b1, 16'hBEEF});
    send_rx("beE", 34);
    repeat (3) tick();
    rx_q.push_back({1'b0, 16'h12AB});
    send_rx("12ab", 36);
    repeat (3) tick();
    check("led_12ab", LED, 16'h12AB);

    SW = 16'h5A5A;
    push_msg(16'h5A5A);
    n = 0;
    while (!(m_tvalid && m_tuser == 12'd3) && n < 50) begin
      tick();
      n++;
    end
    check("hex_reach", n < 50, 1);
    m_tready = 1'b0;
    rstn     = 1'b0;
    tx_q.delete();
    rx_q.push_back({1'b0, 16'h0000});
    tick();
    check("rstmid_tvalid", m_tvalid, 0);
    check("rstmid_led", LED, 0);
    check("rstmid_busy", tx_busy, 0);
    rstn     = 1'b1;
    m_tready = 1'b1;
    push_msg(16'h5A5A);
    wait_idle(100);

    repeat (5) tick();
    check("tx_q_empty", tx_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
